// File: rtl/booth_pkg.sv
// Shared types for the Booth multiplier datapath: digit operations
// and the sequencer state encoding.
package booth_pkg;

    typedef enum logic [1:0] {
        BOOTH_ZERO = 2'b00,
        BOOTH_X    = 2'b01,
        BOOTH_2X   = 2'b11,
        BOOTH_RSVD = 2'b10
    } booth_op_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } seq_state_t;

endpackage

// File: rtl/booth_digit_encoder.sv
// Radix-4 Booth digit recoder: 3-bit multiplier window to
// (operation, negate) pair.
module booth_digit_encoder
    import booth_pkg::*;
(
    input  logic [2:0] window,
    output booth_op_t  op,
    output logic       neg
);

    // 000 and 111 both map to ZERO with neg=0, so no -0 term
    always_comb begin
        op  = BOOTH_ZERO;
        neg = 1'b0;
        unique case (window)
            3'b001, 3'b010: op = BOOTH_X;
            3'b011: op = BOOTH_2X;
            3'b100: begin
                op  = BOOTH_2X;
                neg = 1'b1;
            end
            3'b101, 3'b110: begin
                op  = BOOTH_X;
                neg = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/booth_radix4_sequencer.sv
// Sequential radix-4 Booth multiplier: one digit per cycle,
// valid/ready on both the operand and product sides.
module booth_radix4_sequencer
    import booth_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int ITER = WIDTH / 2;
    localparam int CW   = $clog2(ITER);
    localparam int PW   = 2 * WIDTH;

    seq_state_t       state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH:0]   y_q, y_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [PW-1:0]    prod_q, prod_d;

    booth_op_t        op;
    logic             neg;
    logic [WIDTH+1:0] x_ext, pp_mag, pp;
    logic [PW-1:0]    pp_wide;

    // y_q carries the implicit Y[-1]=0 in bit 0; the window slides by 2
    booth_digit_encoder u_enc (
        .window (y_q[2:0]),
        .op     (op),
        .neg    (neg)
    );

    // Two guard bits keep 2X exact, including X = INT_MIN
    always_comb begin
        x_ext = {{2{x_q[WIDTH-1]}}, x_q};
        unique case (op)
            BOOTH_X:  pp_mag = x_ext;
            BOOTH_2X: pp_mag = x_ext << 1;
            default:  pp_mag = '0;
        endcase
        pp      = neg ? -pp_mag : pp_mag;
        pp_wide = {{(PW-WIDTH-2){pp[WIDTH+1]}}, pp}
                  << {count_q, 1'b0};
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        prod_d  = prod_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    x_d     = multiplicand;
                    y_d     = {multiplier, 1'b0};
                    acc_d   = '0;
                    count_d = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                acc_d   = acc_q + pp_wide;
                y_d     = y_q >> 2;
                count_d = count_q + CW'(1);
                if (count_q == CW'(ITER - 1)) begin
                    prod_d  = acc_q + pp_wide;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            prod_q  <= prod_d;
        end
    end

    assign in_ready  = rst_n && (state_q == S_IDLE);
    assign busy      = (state_q == S_BUSY);
    assign out_valid = (state_q == S_DONE);
    assign product   = prod_q;

endmodule

// File: doc/booth_radix4_sequencer.md
Name: booth_radix4_sequencer

Overview:
Sequential radix-4 Booth multiplier core, sitting on the consuming side of the partial-product interface. It recodes the multiplier operand into Booth digits (op, neg, shift), forms each sign-correct partial product, and accumulates them into a 2*WIDTH-bit signed product over WIDTH/2 cycles. Operands come in and the product goes out over valid/ready handshakes, so the block drops into the datapath as a multi-cycle multiply unit.

Parameters:
WIDTH, 32, operand width in bits; must be even and >= 4.
ITER, WIDTH/2, number of Booth digits (derived; not to be overridden).

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand pair valid
in_ready  output  1  block can accept operands
multiplicand  input  WIDTH  signed multiplicand X
multiplier  input  WIDTH  signed multiplier Y
out_valid  output  1  product valid
out_ready  input  1  downstream accepts product
product  output  2*WIDTH  signed X*Y
busy  output  1  high while in BUSY state

Behaviour:
- Reset (async, rst_n=0): state=IDLE, in_ready=0 while rst_n is low, out_valid=0, product=0, busy=0, digit counter=0, accumulator=0. Reset mid-operation abandons the operation with no output.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, latch X and Y, clear the accumulator, set count=0, go to BUSY.
  - BUSY: in_ready=0 and busy=1. Each cycle, process digit i=count: recode window {Y[2i+1],Y[2i],Y[2i-1]}, with Y[-1]=0. Form the partial product and add it to the accumulator mod 2^(2*WIDTH). Increment count. After digit ITER-1 is processed, go to DONE.
  - DONE: out_valid=1 and product=accumulator, held stable until out_ready. On out_valid&out_ready, go to IDLE.
- Latency: accept at cycle 0, ITER BUSY cycles, out_valid high from cycle ITER+1. For WIDTH=32, out_valid is first high at cycle 17. Throughput is one product per ITER+2 cycles with out_ready tied high.
- in_valid outside IDLE is ignored; the operands are not captured or queued.
- Recoding (window -> op,neg):
  - 000 -> ZERO,0
  - 001 -> X,0
  - 010 -> X,0
  - 011 -> 2X,0
  - 100 -> 2X,1
  - 101 -> X,1
  - 110 -> X,1
  - 111 -> ZERO,0 (neg is forced to 0 for ZERO, so no -0 term)
  - Op encoding: ZERO=2'b00, X=2'b01, 2X=2'b11. 2'b10 is reserved and never generated.
- Partial product:
  - Sign-extend X to WIDTH+2 bits, then shift left by 1 for 2X. The 2X MSB must not be lost; this is required for X=INT_MIN.
  - Two's-complement negate if neg.
  - Sign-extend to 2*WIDTH bits and shift left by 2*i.
  - An equivalent shift-right accumulator implementation is permitted only if product is bit-identical.
- product is signed two's complement over the full 2*WIDTH bits; the result is exact for all inputs, with no overflow.
- out_valid never drops without a handshake. product changes only on entry to DONE.

Decomposition:
- Package booth_pkg:
  - typedef enum logic [1:0] booth_op_t {BOOTH_ZERO=2'b00, BOOTH_X=2'b01, BOOTH_2X=2'b11, BOOTH_RSVD=2'b10}
  - typedef enum logic [1:0] seq_state_t {S_IDLE, S_BUSY, S_DONE}
- Sub-module booth_digit_encoder: combinational, 3-bit window in, booth_op_t op and neg out. It is reused by any future parallel multiplier in the codebase.

Test Plan:
- X=3, Y=5, out_ready=1 -> out_valid first high at cycle 17, product=64'h0000_0000_0000_000F, in_ready low cycles 1-17.
- X=-1, Y=-1 -> product=64'h0000_0000_0000_0001.
- X=32'h8000_0000, Y=32'h8000_0000 -> product=64'h4000_0000_0000_0000, which exercises 2X with INT_MIN.
- X=32'h7FFF_FFFF, Y=-2 -> product=64'hFFFF_FFFF_0000_0002. Then hold out_ready=0 for 5 cycles: out_valid and product stay stable, and in_valid=1 with new operands is ignored.
- Deassert rst_n at BUSY cycle 8 -> out_valid=0, busy=0 and product=0 immediately (async). After release, in_ready=1 and X=7, Y=-3 gives 64'hFFFF_FFFF_FFFF_FFEB.
- 2000 random signed pairs with random out_ready and in_valid gaps -> each product equals the reference signed multiply. No operand is lost or duplicated, checked by counting handshakes.
